// File: rtl/cfg_frame_uart_pkg.sv
// cfg_frame_uart_pkg: shared defaults, FSM encodings and sizing helper for cfg_frame_uart
package cfg_frame_uart_pkg;
   localparam int CMD_BYTES_DEF = 3;
   localparam int RSP_BYTES_DEF = 2;
   localparam int TOUT_CYC_DEF  = 65535;
   localparam int BIT_CYC       = 8;
   typedef enum logic {RX_IDLE = 1'b0, RX_COLLECT = 1'b1} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_SEND = 2'd1, TX_WAIT = 2'd2} tx_state_t;
   function automatic int cnt_w(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction
endpackage

// File: rtl/cfg_frame_uart_if.sv
// cfg_frame_uart_if: frame/response handshake between cfg_frame_uart and its consumer
interface cfg_frame_uart_if #(
   parameter int CMD_BYTES = 3,
   parameter int RSP_BYTES = 2
);
   logic [8*CMD_BYTES-1:0] cfg_data;
   logic                   frm_rdy;
   logic                   clr_frm_rdy;
   logic                   frm_ovr;
   logic                   frm_tout;
   logic [8*RSP_BYTES-1:0] rsp_data;
   logic                   snd_rsp;
   logic                   rsp_busy;
   modport slave (
      output cfg_data, frm_rdy, frm_ovr, frm_tout, rsp_busy,
      input  clr_frm_rdy, rsp_data, snd_rsp
   );
   modport master (
      input  cfg_data, frm_rdy, frm_ovr, frm_tout, rsp_busy,
      output clr_frm_rdy, rsp_data, snd_rsp
   );
endinterface

// File: rtl/cfg_frame_uart_uart.sv
// cfg_frame_uart_uart: 8N1 UART, BIT_CYC clocks per bit, one-cycle tx_done, rdy held until clr_rdy
module cfg_frame_uart_uart
   import cfg_frame_uart_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic       clr_rdy,
   output logic       tx_done,
   output logic       rdy,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       TX_C,
   input  logic       RX_C
);
   localparam int BW = $clog2(BIT_CYC);
   logic [9:0]    r_tx_sh;
   logic [7:0]    r_rx_sh;
   logic [3:0]    r_tx_bit, r_rx_bit;
   logic [BW-1:0] r_tx_baud, r_rx_baud;
   logic [1:0]    r_rx_ff;
   logic          r_tx_busy, r_rx_busy, r_tx_done, r_rdy;
   logic          w_tx_tick, w_rx_tick;
   assign w_tx_tick = r_tx_busy && r_tx_baud == BW'(BIT_CYC - 1);
   assign w_rx_tick = r_rx_busy && r_rx_baud == '0;
   assign TX_C      = r_tx_sh[0];
   assign tx_done   = r_tx_done;
   assign rdy       = r_rdy;
   assign rx_data   = r_rx_sh;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_tx_sh   <= '1;
         r_tx_bit  <= '0;
         r_tx_baud <= '0;
         r_tx_busy <= 1'b0;
         r_tx_done <= 1'b0;
      end else begin
         r_tx_done <= w_tx_tick && r_tx_bit == 4'd9;
         if (trmt && !r_tx_busy) begin
            r_tx_sh   <= {1'b1, tx_data, 1'b0};
            r_tx_bit  <= '0;
            r_tx_baud <= '0;
            r_tx_busy <= 1'b1;
         end else if (r_tx_busy) begin
            r_tx_baud <= w_tx_tick ? '0 : r_tx_baud + 1'b1;
            if (w_tx_tick) begin
               r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
               r_tx_bit  <= r_tx_bit + 1'b1;
               r_tx_busy <= r_tx_bit != 4'd9;
            end
         end
      end
   // start bit is sampled first and shifted out again by the eight data samples
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rx_ff   <= '1;
         r_rx_sh   <= '0;
         r_rx_bit  <= '0;
         r_rx_baud <= '0;
         r_rx_busy <= 1'b0;
         r_rdy     <= 1'b0;
      end else begin
         r_rx_ff <= {r_rx_ff[0], RX_C};
         r_rdy   <= (w_rx_tick && r_rx_bit == 4'd9) ? 1'b1 : clr_rdy ? 1'b0 : r_rdy;
         if (!r_rx_busy && !r_rx_ff[1]) begin
            r_rx_busy <= 1'b1;
            r_rx_bit  <= '0;
            r_rx_baud <= BW'(BIT_CYC / 2 - 2);
         end else if (r_rx_busy) begin
            r_rx_baud <= w_rx_tick ? BW'(BIT_CYC - 1) : r_rx_baud - 1'b1;
            if (w_rx_tick) begin
               if (r_rx_bit != 4'd9) r_rx_sh <= {r_rx_ff[1], r_rx_sh[7:1]};
               r_rx_bit  <= r_rx_bit + 1'b1;
               r_rx_busy <= r_rx_bit != 4'd9;
            end
         end
      end
endmodule

// File: rtl/cfg_frame_uart.sv
// cfg_frame_uart: collects CMD_BYTES-byte command frames from RX_C and sends RSP_BYTES-byte responses on TX_C
module cfg_frame_uart
   import cfg_frame_uart_pkg::*;
#(
   parameter int CMD_BYTES = CMD_BYTES_DEF,
   parameter int RSP_BYTES = RSP_BYTES_DEF,
   parameter int TOUT_CYC  = TOUT_CYC_DEF
)(
   input  logic clk,
   input  logic rst_n,
   input  logic RX_C,
   output logic TX_C,
   cfg_frame_uart_if.slave bus
);
   localparam int CW = cnt_w(CMD_BYTES, RSP_BYTES);
   localparam int TW = $clog2(TOUT_CYC + 1);
   localparam int CB = 8 * CMD_BYTES;
   localparam int RB = 8 * RSP_BYTES;
   rx_state_t     r_rx_st, w_rx_nxt;
   tx_state_t     r_tx_st, w_tx_nxt;
   logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt, r_tx_cnt;
   logic [TW-1:0] r_idle;
   logic [CB-1:0] r_shadow, r_cfg, w_shift;
   logic [RB-1:0] r_tx_sh;
   logic          r_frm_rdy, r_frm_ovr, r_frm_tout;
   logic          w_trmt, w_clr_rdy, w_tx_done, w_rdy, w_done, w_tout, w_tx_last;
   logic [7:0]    w_tx_data, w_rx_data;
   cfg_frame_uart_uart u_uart (
      .clk     (clk),
      .rst_n   (rst_n),
      .trmt    (w_trmt),
      .clr_rdy (w_clr_rdy),
      .tx_done (w_tx_done),
      .rdy     (w_rdy),
      .tx_data (w_tx_data),
      .rx_data (w_rx_data),
      .TX_C    (TX_C),
      .RX_C    (RX_C)
   );
   assign bus.cfg_data = r_cfg;
   assign bus.frm_rdy  = r_frm_rdy;
   assign bus.frm_ovr  = r_frm_ovr;
   assign bus.frm_tout = r_frm_tout;
   assign bus.rsp_busy = r_tx_st != TX_IDLE;
   assign w_shift      = CB'({r_shadow, w_rx_data});
   always_comb begin
      w_clr_rdy    = w_rdy;
      w_done       = w_rdy && r_rx_cnt == CW'(CMD_BYTES - 1);
      w_tout       = r_rx_st == RX_COLLECT && !w_rdy && r_idle == TW'(TOUT_CYC - 1);
      w_rx_nxt     = r_rx_st;
      w_rx_cnt_nxt = r_rx_cnt;
      if (w_done || w_tout) begin
         w_rx_nxt     = RX_IDLE;
         w_rx_cnt_nxt = '0;
      end else if (w_rdy) begin
         w_rx_nxt     = RX_COLLECT;
         w_rx_cnt_nxt = r_rx_cnt + 1'b1;
      end
   end
   // a completion coinciding with clr_frm_rdy keeps frm_rdy but does not raise frm_ovr
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_rx_st    <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_idle     <= '0;
         r_shadow   <= '0;
         r_cfg      <= '0;
         r_frm_rdy  <= 1'b0;
         r_frm_ovr  <= 1'b0;
         r_frm_tout <= 1'b0;
      end else begin
         r_rx_st    <= w_rx_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_idle     <= (r_rx_st == RX_COLLECT && !w_rdy && !w_tout) ? r_idle + 1'b1 : '0;
         r_frm_tout <= w_tout;
         r_frm_rdy  <= w_done | (r_frm_rdy & ~bus.clr_frm_rdy);
         r_frm_ovr  <= ~bus.clr_frm_rdy & (r_frm_ovr | (w_done & r_frm_rdy));
         if (w_rdy) r_shadow <= w_shift;
         if (w_done) r_cfg <= w_shift;
      end
   always_comb begin
      w_trmt    = r_tx_st == TX_SEND;
      w_tx_data = r_tx_sh[RB-1 -: 8];
      w_tx_last = r_tx_cnt == CW'(RSP_BYTES - 1);
      w_tx_nxt  = r_tx_st == TX_IDLE ? (bus.snd_rsp ? TX_SEND : TX_IDLE) :
                  r_tx_st == TX_SEND ? TX_WAIT :
                  !w_tx_done ? TX_WAIT : w_tx_last ? TX_IDLE : TX_SEND;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_tx_st  <= TX_IDLE;
         r_tx_cnt <= '0;
         r_tx_sh  <= '0;
      end else begin
         r_tx_st <= w_tx_nxt;
         if (r_tx_st == TX_IDLE && bus.snd_rsp) begin
            r_tx_sh  <= bus.rsp_data;
            r_tx_cnt <= '0;
         end else if (r_tx_st == TX_WAIT && w_tx_done) begin
            r_tx_sh  <= r_tx_sh << 8;
            r_tx_cnt <= w_tx_last ? '0 : r_tx_cnt + 1'b1;
         end
      end
endmodule

// File: tb/tb_cfg_frame_uart.sv
// tb_cfg_frame_uart: scoreboard bench; default instance u0 and a CMD_BYTES=1/RSP_BYTES=4 instance u1
module tb_cfg_frame_uart;
   import cfg_frame_uart_pkg::*;
   localparam int CB0 = 8 * CMD_BYTES_DEF;
   logic clk = 1'b0, rst_n = 1'b0, rx0 = 1'b1, rx1 = 1'b1;
   logic tx0, tx1;
   int checks = 0, errors = 0, n_t0 = 0, n_t1 = 0, lat = 0;
   logic [CB0-1:0] q_f0[$];
   logic [7:0]     q_f1[$], q_t0[$], q_t1[$];
   cfg_frame_uart_if #(.CMD_BYTES(CMD_BYTES_DEF), .RSP_BYTES(RSP_BYTES_DEF)) b0();
   cfg_frame_uart_if #(.CMD_BYTES(1), .RSP_BYTES(4)) b1();
   cfg_frame_uart u0 (.clk(clk), .rst_n(rst_n), .RX_C(rx0), .TX_C(tx0), .bus(b0));
   cfg_frame_uart #(.CMD_BYTES(1), .RSP_BYTES(4), .TOUT_CYC(16)) u1 (
      .clk(clk), .rst_n(rst_n), .RX_C(rx1), .TX_C(tx1), .bus(b1));
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic unexp(input string nm, input logic [31:0] act);
      checks++;
      errors++;
      $display("FAIL %s unexpected output act=%h", nm, act);
   endtask

   function automatic logic txl(input int w);
      return (w == 0) ? tx0 : tx1;
   endfunction

   // serial decoder for TX_C; a byte overlapping reset is dropped
   task automatic tx_mon(input int w);
      logic [7:0] b;
      logic ab;
      forever begin
         @(negedge clk);
         if (txl(w) === 1'b0) begin
            ab = !rst_n;
            repeat (BIT_CYC / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (BIT_CYC) @(negedge clk);
               b[i] = txl(w);
               ab |= !rst_n;
            end
            repeat (BIT_CYC) @(negedge clk);
            ab |= !rst_n;
            if (!ab) begin
               chk(w == 0 ? "tx0_stop" : "tx1_stop", 32'(txl(w)), 32'd1);
               if (w == 0) begin
                  if (q_t0.size() == 0) unexp("tx0", 32'(b));
                  else chk("tx0_byte", 32'(b), 32'(q_t0.pop_front()));
                  n_t0++;
               end else begin
                  if (q_t1.size() == 0) unexp("tx1", 32'(b));
                  else chk("tx1_byte", 32'(b), 32'(q_t1.pop_front()));
                  n_t1++;
               end
            end
         end
      end
   endtask

   initial tx_mon(0);
   initial tx_mon(1);

   initial begin : frm_mon
      logic p0, p1;
      p0 = 1'b0;
      p1 = 1'b0;
      forever begin
         @(negedge clk);
         if (b0.frm_rdy === 1'b1 && !p0) begin
            if (q_f0.size() == 0) unexp("frm0", 32'(b0.cfg_data));
            else chk("frm0_cfg", 32'(b0.cfg_data), 32'(q_f0.pop_front()));
         end
         if (b1.frm_rdy === 1'b1 && !p1) begin
            if (q_f1.size() == 0) unexp("frm1", 32'(b1.cfg_data));
            else chk("frm1_cfg", 32'(b1.cfg_data), 32'(q_f1.pop_front()));
         end
         p0 = b0.frm_rdy === 1'b1;
         p1 = b1.frm_rdy === 1'b1;
      end
   end

   task automatic send_byte(input int w, input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         if (w == 0) rx0 = f[i];
         else rx1 = f[i];
         repeat (BIT_CYC) @(negedge clk);
      end
   endtask

   task automatic wait_rdy(input int w, input string nm);
      int n;
      n = 0;
      while ((w == 0 ? b0.frm_rdy : b1.frm_rdy) !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < 2000), 32'd1);
   endtask

   task automatic wait_idle(input int w, input string nm);
      int n;
      n = 0;
      while ((w == 0 ? b0.rsp_busy : b1.rsp_busy) !== 1'b0 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk(nm, 32'(n < 5000), 32'd1);
   endtask

   task automatic clr(input int w);
      if (w == 0) b0.clr_frm_rdy = 1'b1;
      else b1.clr_frm_rdy = 1'b1;
      @(negedge clk);
      b0.clr_frm_rdy = 1'b0;
      b1.clr_frm_rdy = 1'b0;
   endtask

   task automatic snd(input int w);
      if (w == 0) b0.snd_rsp = 1'b1;
      else b1.snd_rsp = 1'b1;
      @(negedge clk);
      b0.snd_rsp = 1'b0;
      b1.snd_rsp = 1'b0;
   endtask

   initial begin
      logic [7:0] cmd1 [3];
      int tp, first, nt;
      cmd1 = '{8'h5A, 8'hA5, 8'h3C};
      b0.clr_frm_rdy = 1'b0; b0.snd_rsp = 1'b0; b0.rsp_data = '0;
      b1.clr_frm_rdy = 1'b0; b1.snd_rsp = 1'b0; b1.rsp_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_cfg", 32'(b0.cfg_data), 32'd0);
      chk("rst_rdy", 32'(b0.frm_rdy), 32'd0);
      chk("rst_ovr", 32'(b0.frm_ovr), 32'd0);
      chk("rst_tout", 32'(b0.frm_tout), 32'd0);
      chk("rst_busy", 32'(b0.rsp_busy), 32'd0);
      chk("rst_txc", 32'(tx0), 32'd1);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // basic frame; also measures last-byte-start to frm_rdy latency
      q_f0.push_back(24'hA53C7E);
      send_byte(0, 8'hA5);
      send_byte(0, 8'h3C);
      fork
         send_byte(0, 8'h7E);
         while (b0.frm_rdy !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
         end
      join
      chk("f1_rdy", 32'(b0.frm_rdy), 32'd1);
      chk("f1_ovr", 32'(b0.frm_ovr), 32'd0);
      clr(0);
      chk("f1_clr", 32'(b0.frm_rdy), 32'd0);

      // partial frame then idle past the timeout
      send_byte(0, 8'h11);
      send_byte(0, 8'h22);
      tp = 0;
      first = -1;
      for (int c = 1; c <= TOUT_CYC_DEF + 100; c++) begin
         @(negedge clk);
         if (b0.frm_tout === 1'b1) begin
            tp++;
            if (first < 0) first = c;
         end
      end
      chk("tout_cycles", 32'(tp), 32'd1);
      chk("tout_when", 32'(first >= TOUT_CYC_DEF - 15 && first <= TOUT_CYC_DEF + 15), 32'd1);
      chk("tout_rdy", 32'(b0.frm_rdy), 32'd0);
      chk("tout_cfg", 32'(b0.cfg_data), 32'h00A53C7E);
      q_f0.push_back(24'h010203);
      send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03);
      wait_rdy(0, "f2_wait");
      clr(0);

      // overrun, then clear coincident with a completion
      q_f0.push_back(24'h010203);
      send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03);
      send_byte(0, 8'h04); send_byte(0, 8'h05); send_byte(0, 8'h06);
      chk("ovr_cfg", 32'(b0.cfg_data), 32'h00040506);
      chk("ovr_flag", 32'(b0.frm_ovr), 32'd1);
      chk("ovr_rdy", 32'(b0.frm_rdy), 32'd1);
      send_byte(0, 8'h07);
      send_byte(0, 8'h08);
      fork
         send_byte(0, 8'h09);
         begin
            repeat (lat - 1) @(negedge clk);
            b0.clr_frm_rdy = 1'b1;
            @(negedge clk);
            b0.clr_frm_rdy = 1'b0;
         end
      join
      chk("coin_rdy", 32'(b0.frm_rdy), 32'd1);
      chk("coin_ovr", 32'(b0.frm_ovr), 32'd0);
      chk("coin_cfg", 32'(b0.cfg_data), 32'h00070809);
      clr(0);
      chk("coin_clr", 32'(b0.frm_rdy), 32'd0);

      // two-byte response; a second request mid-frame is ignored
      q_t0.push_back(8'hBE);
      q_t0.push_back(8'hEF);
      b0.rsp_data = 16'hBEEF;
      snd(0);
      chk("busy_on", 32'(b0.rsp_busy), 32'd1);
      repeat (100) @(negedge clk);
      b0.rsp_data = 16'h1234;
      snd(0);
      wait_idle(0, "tx0_idle");
      chk("tx0_cnt_idle", 32'(n_t0), 32'd2);
      repeat (300) @(negedge clk);
      chk("tx0_cnt_after", 32'(n_t0), 32'd2);

      // single-byte frames while a four-byte response is in flight
      b1.rsp_data = 32'h01020304;
      q_t1.push_back(8'h01); q_t1.push_back(8'h02);
      q_t1.push_back(8'h03); q_t1.push_back(8'h04);
      snd(1);
      fork
         for (int i = 0; i < 3; i++) begin
            q_f1.push_back(cmd1[i]);
            send_byte(1, cmd1[i]);
            wait_rdy(1, "f1b_wait");
            clr(1);
         end
         begin
            wait_idle(1, "tx1_idle");
            chk("tx1_cnt", 32'(n_t1), 32'd4);
         end
      join

      // reset mid-frame and mid-response
      send_byte(0, 8'hAA);
      send_byte(0, 8'hBB);
      b0.rsp_data = 16'hCAFE;
      snd(0);
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_cfg", 32'(b0.cfg_data), 32'd0);
      chk("mrst_busy", 32'(b0.rsp_busy), 32'd0);
      chk("mrst_txc", 32'(tx0), 32'd1);
      chk("mrst_ovr", 32'(b0.frm_ovr), 32'd0);
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      nt = n_t0;
      q_f0.push_back(24'h102030);
      send_byte(0, 8'h10); send_byte(0, 8'h20); send_byte(0, 8'h30);
      wait_rdy(0, "post_rst_wait");
      chk("post_rst_ovr", 32'(b0.frm_ovr), 32'd0);
      repeat (300) @(negedge clk);
      chk("post_rst_tx", 32'(n_t0), 32'(nt));
      chk("post_rst_busy", 32'(b0.rsp_busy), 32'd0);
      clr(0);

      chk("q_f0_left", 32'(q_f0.size()), 32'd0);
      chk("q_f1_left", 32'(q_f1.size()), 32'd0);
      chk("q_t0_left", 32'(q_t0.size()), 32'd0);
      chk("q_t1_left", 32'(q_t1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cfg_frame_uart.md
CFG_FRAME_UART -- requirements
Module: cfg_frame_uart

Interface
REQ-001 Parameter CMD_BYTES, default 3: bytes per received command frame; legal range 1..8.
REQ-002 Parameter RSP_BYTES, default 2: bytes per transmitted response frame; legal range 1..8.
REQ-003 Parameter TOUT_CYC, default 65535: maximum idle clk cycles between bytes of a partial command frame; legal range 16..2^20-1.
REQ-004 Port clk, input, 1: single clock; all logic on posedge clk.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port RX_C, input, 1: serial command line.
REQ-007 Port TX_C, output, 1: serial response line.
REQ-008 Port cfg_data, output, 8*CMD_BYTES: last complete command frame, first byte received in the MS byte.
REQ-009 Port frm_rdy, output, 1: complete frame available.
REQ-010 Port clr_frm_rdy, input, 1: consumer acknowledge; clears frm_rdy and frm_ovr.
REQ-011 Port frm_ovr, output, 1: sticky flag; a frame completed while frm_rdy was already 1.
REQ-012 Port frm_tout, output, 1: one-cycle pulse; partial frame discarded on timeout.
REQ-013 Port rsp_data, input, 8*RSP_BYTES: response word; MS byte sent first.
REQ-014 Port snd_rsp, input, 1: request to send rsp_data.
REQ-015 Port rsp_busy, output, 1: response transmission in progress.

Function
REQ-016 RX path and TX path SHALL run independently (full duplex), each with its own FSM.
REQ-017 RX FSM states RX_IDLE (byte count 0) and RX_COLLECT; each UART rdy SHALL shift rx_data into an 8*CMD_BYTES shadow register and pulse clr_rdy for exactly one cycle in the same cycle.
REQ-018 On byte CMD_BYTES, cfg_data SHALL load the full shadow value in one cycle (never partially updated), byte count returns to 0, FSM to RX_IDLE; frm_rdy SHALL be 1 the following cycle.
REQ-019 CMD_BYTES=1: every accepted byte completes a frame; RX_COLLECT is never entered.
REQ-020 In RX_COLLECT an idle counter SHALL reset on every rdy; on reaching TOUT_CYC the partial frame SHALL be discarded, count cleared, FSM to RX_IDLE, frm_tout pulsed one cycle; cfg_data, frm_rdy unchanged.
REQ-021 Frame completion while frm_rdy=1 SHALL set frm_ovr and overwrite cfg_data.
REQ-022 clr_frm_rdy SHALL clear frm_rdy and frm_ovr next cycle; simultaneous completion and clr_frm_rdy: set wins (frm_rdy=1, frm_ovr unchanged by that completion).
REQ-023 TX FSM states TX_IDLE, TX_SEND, TX_WAIT; snd_rsp sampled high in TX_IDLE SHALL capture rsp_data into a shift register and enter TX_SEND; rsp_busy=1 from the next cycle.
REQ-024 TX_SEND SHALL assert trmt for exactly one cycle with tx_data = current MS byte, then enter TX_WAIT.
REQ-025 tx_done in TX_WAIT SHALL shift the register one byte and re-enter TX_SEND if bytes remain, else enter TX_IDLE with rsp_busy=0 the next cycle.
REQ-026 snd_rsp while rsp_busy=1 SHALL be ignored; rsp_data changes after capture SHALL not affect the frame in flight.
REQ-027 Byte counters SHALL be $clog2(max(CMD_BYTES,RSP_BYTES)+1) bits wide; no wrap beyond the frame length.

Reset
REQ-028 rst_n low SHALL asynchronously force cfg_data=0, frm_rdy=0, frm_ovr=0, frm_tout=0, rsp_busy=0, trmt=0, clr_rdy=0, counters=0, FSMs to RX_IDLE/TX_IDLE, TX_C idle high (via UART).
REQ-029 Reset mid-frame or mid-response SHALL abandon it; after release, no residual byte SHALL be counted or sent.

Structure
REQ-030 RX/TX state encodings and the CMD_BYTES/RSP_BYTES/TOUT_CYC defaults SHALL live in a shared package include used by this block and its bench.
REQ-031 Exactly one sub-module: the existing UART (ports clk, rst_n, trmt, clr_rdy, tx_done, rdy, tx_data, rx_data, TX_C, RX_C), instantiated unchanged.

Verification
REQ-032 Defaults; send 0xA5,0x3C,0x7E -> cfg_data=0xA53C7E, frm_rdy=1, frm_ovr=0; clr_frm_rdy -> frm_rdy=0.
REQ-033 Send 0x11,0x22 then idle 65535 cycles -> one-cycle frm_tout; then 0x01,0x02,0x03 -> cfg_data=0x010203.
REQ-034 Two frames 0x010203, 0x040506 without clr -> cfg_data=0x040506, frm_ovr=1; clr_frm_rdy coincident with a third frame's completion -> frm_rdy=1.
REQ-035 rsp_data=0xBEEF, snd_rsp pulse -> TX_C carries 0xBE then 0xEF, exactly two trmt pulses, rsp_busy falls after second tx_done; second snd_rsp mid-frame ignored.
REQ-036 CMD_BYTES=1, RSP_BYTES=4: byte 0x5A -> cfg_data=0x5A each byte; rsp_data=0x01020304 -> bytes 01,02,03,04 while a command arrives concurrently.
REQ-037 rst_n low after second command byte and mid-response -> all outputs zero; subsequent full frame decodes correctly.
